// File: rtl/alpaca_pkg.sv
// Shared types and constants for the alpaca radix-2 FFT stage chain.
package alpaca_pkg;

  localparam int DEF_FFT_LEN = 16;
  localparam int WIDTH       = 16;
  localparam int IDX_W       = $clog2(DEF_FFT_LEN / 2);

  // Complex sample, imaginary part in the upper half of the word.
  typedef struct packed {
    logic signed [WIDTH-1:0] im;
    logic signed [WIDTH-1:0] re;
  } cx_t;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    PAIR = 1'b1
  } state_e;

endpackage

// File: rtl/alpaca_axis_if.sv
// AXI-Stream style link shared by the feeder and the butterfly.
interface alpaca_axis #(
  parameter int DW = 32,
  parameter int UW = 8
) ();

  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;
  logic [UW-1:0] tuser;

  modport MST (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport SLV (input tdata, input tvalid, input tlast, input tuser, output tready);

endinterface

// File: rtl/alpaca_half_frame_buffer.sv
// Half-frame sample store: one synchronous write port, one asynchronous
// read port. Contents are intentionally not reset.
module alpaca_half_frame_buffer
  import alpaca_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  cx_t           wr_data,
  input  logic [AW-1:0] rd_addr,
  output cx_t           rd_data
);

  cx_t mem [DEPTH];

  // Capture first-half samples.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/alpaca_butterfly_feeder.sv
// Serial-to-pair feeder for the radix-2 butterfly: stores the first half of
// each frame, then emits x[n] on x1 alongside the incoming x[n+N/2] on x2.
// Optional build macro: ALPACA_FEEDER_DROPCNT_EN adds the drop_cnt port.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   FILL  | accepting first half-frame samples into the buffer
//   PAIR  | accepting second half, emitting buffered/incoming pairs
module alpaca_butterfly_feeder
  import alpaca_pkg::*;
#(
  parameter int FFT_LEN = DEF_FFT_LEN,
  parameter int TUSER   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  alpaca_axis.SLV     s_axis,
  alpaca_axis.MST     x1,
  alpaca_axis.MST     x2,
  output logic        frame_err
`ifdef ALPACA_FEEDER_DROPCNT_EN
  ,
  output logic [15:0] drop_cnt
`endif
);

  localparam int HALF = FFT_LEN / 2;
  localparam int IW   = $clog2(HALF);
  localparam logic [IW-1:0] IDX_LAST = IW'(HALF - 1);
  localparam logic [0:0] S_FILL = FILL;
  localparam logic [0:0] S_PAIR = PAIR;

  logic [0:0]       state;
  logic [IW-1:0]    idx;
  logic [TUSER-1:0] frame_cnt;
  logic             out_v;
  cx_t              o1_data;
  cx_t              o2_data;
  logic             o_last;
  logic [TUSER-1:0] o_user;
  cx_t              rd_data;
  cx_t              in_data;
  logic             rdy;
  logic             in_hs;
  logic             out_done;
  logic             last_pos;
  logic             early_last;
  logic             missing_last;
  logic             pair_load;
  logic             wr_en;
  logic             unused_tuser;

  assign unused_tuser = ^s_axis.tuser;
  assign in_data      = cx_t'(s_axis.tdata);

  // Handshake and framing decode.
  always_comb begin
    out_done     = out_v & x1.tready & x2.tready;
    rdy          = rst_n & ((state == S_FILL) | ~out_v | (x1.tready & x2.tready));
    in_hs        = s_axis.tvalid & rdy;
    last_pos     = (state == S_PAIR) && (idx == IDX_LAST);
    early_last   = in_hs & s_axis.tlast & ~last_pos;
    missing_last = in_hs & ~s_axis.tlast & last_pos;
    pair_load    = in_hs & (state == S_PAIR) & ~early_last;
    wr_en        = in_hs & (state == S_FILL);
  end

  assign s_axis.tready = rdy;

  alpaca_half_frame_buffer #(
    .DEPTH (HALF),
    .AW    (IW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (idx),
    .wr_data (in_data),
    .rd_addr (idx),
    .rd_data (rd_data)
  );

  // Frame sequencing: FILL -> PAIR -> FILL, early tlast resyncs to FILL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FILL;
      idx       <= '0;
      frame_cnt <= '0;
    end else if (early_last) begin
      state <= S_FILL;
      idx   <= '0;
    end else if (in_hs) begin
      if (idx == IDX_LAST) begin
        idx <= '0;
        if (state == S_PAIR) begin
          state     <= S_FILL;
          frame_cnt <= frame_cnt + 1'b1;
        end else begin
          state <= S_PAIR;
        end
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Output pair register; a new load may overlap the completion of the old beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v   <= 1'b0;
      o1_data <= '0;
      o2_data <= '0;
      o_last  <= 1'b0;
      o_user  <= '0;
    end else if (pair_load) begin
      out_v   <= 1'b1;
      o1_data <= rd_data;
      o2_data <= in_data;
      o_last  <= last_pos;
      o_user  <= frame_cnt;
    end else if (out_done) begin
      out_v <= 1'b0;
    end
  end

  assign x1.tvalid = out_v;
  assign x1.tdata  = o1_data;
  assign x1.tlast  = o_last;
  assign x1.tuser  = o_user;
  assign x2.tvalid = out_v;
  assign x2.tdata  = o2_data;
  assign x2.tlast  = o_last;
  assign x2.tuser  = o_user;

  // Sticky framing error on early or missing tlast.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         frame_err <= 1'b0;
    else if (early_last | missing_last) frame_err <= 1'b1;
  end

`ifdef ALPACA_FEEDER_DROPCNT_EN
  logic [16:0] drop_sum;

  // Samples lost on resync are the frame position plus one.
  assign drop_sum = {1'b0, drop_cnt} + 17'({state, idx}) + 17'd1;

  // Saturating count of discarded samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          drop_cnt <= '0;
    else if (early_last) drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end
`endif

endmodule

// File: doc/alpaca_butterfly_feeder.md
Name: alpaca_butterfly_feeder

Overview:
Transmit side of the radix-2 butterfly input interface: converts one serial complex stream, one sample per clock in FFT_LEN-sample frames, into the paired x1/x2 AXIS streams the butterfly consumes. The first half-frame is stored in a half-frame buffer. During the second half each incoming sample x[n+N/2] is emitted on x2, together with the stored x[n] on x1. Sits directly upstream of alpaca_butterfly in the FFT stage chain.

Parameters:
FFT_LEN, 16, frame length N; power of two, >= 4
WIDTH, 16, bits per real/imag component of cx_t
TUSER, 8, width of output tuser (frame counter)

Ports:
clk  input  1  stage clock
rst_n  input  1  asynchronous, active-low reset
s_axis  alpaca_axis.SLV  cx_t (2*WIDTH), tuser unused  serial input: tdata, tvalid, tlast, tready
x1  alpaca_axis.MST  cx_t, TUSER  butterfly upper input x[n]
x2  alpaca_axis.MST  cx_t, TUSER  butterfly lower input x[n+N/2]
frame_err  output  1  sticky framing-error flag

Behaviour:
- Reset (rst_n=0, async assert, sync deassert): state=FILL, idx=0, frame_cnt=0, x1/x2 tvalid=0, tlast=0, tdata=0, tuser=0, frame_err=0, s_axis.tready=0 while in reset. Buffer contents are not reset.
- FILL state, idx 0..N/2-1:
  - s_axis.tready=1.
  - On handshake: buf[idx]<=tdata, idx++.
  - idx reaching N/2-1 with handshake -> PAIR, idx=0.
- PAIR state, idx 0..N/2-1:
  - s_axis.tready = !out_v | (x1.tready & x2.tready).
  - On handshake, output register loads x1.tdata<=buf[idx], x2.tdata<=s_axis.tdata, tlast<=(idx==N/2-1) on both, tuser<=frame_cnt on both, out_v<=1. idx++.
  - Last pair: -> FILL, idx=0, frame_cnt++ (wraps 2^TUSER-1 -> 0).
- x1.tvalid = x2.tvalid = out_v; both streams always move together.
- An output beat completes only when x1.tready & x2.tready. With one ready only, the beat is held with tdata stable.
- out_v clears on completion when no new load occurs in the same cycle.
- Latency: a second-half sample accepted at edge t appears on x1/x2 after edge t (one register stage). Full throughput with ready held high.
- Buffer read is asynchronous (LUTRAM/register array), addressed by idx.
- Frame overlap: the next frame's FILL may begin while the last pair is still held in the output register. buf overwrite is safe because the pair is already captured.
- tlast checking:
  - s_axis.tlast with frame position != N-1: set frame_err (sticky until reset), discard the partial frame, go to FILL with idx=0. frame_cnt is not incremented.
  - Missing tlast at position N-1: set frame_err, process the frame normally.
- A simultaneous input handshake and output completion in PAIR is a normal pipelined transfer: no bubble, no loss.

Optional Feature:
ALPACA_FEEDER_DROPCNT_EN
- Defined: adds output port drop_cnt [15:0]. Reset 0. Increments by the number of samples discarded on an early-tlast resync (frame position+1), saturates at 16'hFFFF.
- Undefined: port and counter absent; frame_err only.

Decomposition:
- Shared package alpaca_pkg holds:
  - WIDTH
  - cx_t packed struct (im over re, signed)
  - state enum {FILL, PAIR}
  - clog2-derived IDX_W = $clog2(FFT_LEN/2)
- alpaca_axis interface is shared with the butterfly.
- One sub-module: alpaca_half_frame_buffer. Depth N/2 of cx_t, one write port (wr_en, wr_addr, wr_data), one asynchronous read port (rd_addr, rd_data). No reset.

Test Plan:
1. FFT_LEN=16, input ramp re=im=0..15, tlast on 15, ready=1 -> 8 beats with x1=k+jk, x2=(k+8)+j(k+8) for k=0..7. tlast only on k=7. tuser=0. frame_err=0.
2. Two back-to-back frames 0..15 then 16..31 -> second frame x1=16..23, x2=24..31, tuser=1. No idle cycle between frames at the input.
3. Backpressure: x2.tready low for 3 cycles at pair k=3 -> s_axis.tready low, x1/x2 hold 3/11 stable, then resume. All 8 pairs delivered in order, none duplicated.
4. Early tlast at frame position 5 -> frame_err=1, no x1/x2 output for that frame. The following clean frame 0..15 outputs correctly with tuser=0. With ALPACA_FEEDER_DROPCNT_EN, drop_cnt=6.
5. Reset pulse mid-PAIR at k=4 -> x1/x2 tvalid=0 immediately (async). After release, a fresh frame produces full output from k=0 with tuser=0.
6. 257 consecutive frames -> tuser sequence 0..255 then 0, with tlast once per frame.
